wb_bus_arbiter: RTL and testbench

Round-robin Wishbone bus arbiter that shares one shared-bus Wishbone slave port among up to N masters, e.g. the NIC `wb_master_interface` and local cores/DMA. It observes each master's CYC_O as its request and produces the per-master `gnt_wb` grant that masters and slaves consume. Ownership is held for the whole bus cycle, i.e. while the owner keeps CYC asserted. A hold-time watchdog aborts a runaway owner with a one-cycle error pulse to that master.

---
 rtl/wb_bus_arbiter_if.sv | 29 ++
 rtl/wb_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_bus_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_if.sv
// Request/grant signal bundle between the Wishbone masters and the round-robin arbiter.
// The master modport is the side that issues grants (the arbiter); slave is the requesters' side.
interface wb_bus_arbiter_if #(
    parameter int N_MASTERS = 4
);
    localparam int N_BITS_ID = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] cyc_i;
    logic [N_MASTERS-1:0] gnt_o;
    logic [N_BITS_ID-1:0] gnt_id_o;
    logic                 busy_o;
    logic [N_MASTERS-1:0] err_o;

    modport master (
        input  cyc_i,
        output gnt_o,
        output gnt_id_o,
        output busy_o,
        output err_o
    );

    modport slave (
        output cyc_i,
        input  gnt_o,
        input  gnt_id_o,
        input  busy_o,
        input  err_o
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone bus arbiter: holds ownership for a whole CYC cycle and
// aborts an owner that keeps the bus longer than MAX_HOLD_CYCLES with an err pulse.
module wb_bus_arbiter #(
    parameter int N_MASTERS       = 4,
    parameter int MAX_HOLD_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    wb_bus_arbiter_if.master    bus
);
    localparam int N_BITS_ID   = $clog2(N_MASTERS);
    localparam int N_BITS_HOLD = (MAX_HOLD_CYCLES == 0) ? 1 : $clog2(MAX_HOLD_CYCLES + 1);
    localparam bit WD_EN       = (MAX_HOLD_CYCLES != 0);
    localparam logic [N_BITS_HOLD-1:0] HOLD_LAST = N_BITS_HOLD'(WD_EN ? MAX_HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [N_MASTERS-1:0]   err_q, err_d;
    logic [N_BITS_ID-1:0]   id_q, id_d;
    logic [N_BITS_ID-1:0]   last_q, last_d;
    logic [N_BITS_HOLD-1:0] hold_q, hold_d;
    logic [N_BITS_ID-1:0]   sel;

    // First requester after the most recent owner, wrapping modulo N_MASTERS.
    function automatic logic [N_BITS_ID-1:0] rr_pick(
        input logic [N_MASTERS-1:0] req,
        input logic [N_BITS_ID-1:0] ptr
    );
        logic [N_BITS_ID-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = (int'(ptr) + i) % N_MASTERS;
            if (!found && req[idx]) begin
                pick  = N_BITS_ID'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        hold_d  = hold_q;
        err_d   = '0;
        sel     = rr_pick(bus.cyc_i, last_q);

        unique case (state_q)
            IDLE: begin
                if (|bus.cyc_i) begin
                    gnt_d   = N_MASTERS'(1) << sel;
                    id_d    = sel;
                    last_d  = sel;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Release beats timeout when both happen on the same edge.
                if (!bus.cyc_i[id_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (WD_EN && hold_q == HOLD_LAST) begin
                    gnt_d        = '0;
                    err_d[id_q]  = 1'b1;
                    state_d      = ABORT;
                end else if (WD_EN) begin
                    hold_d = hold_q + N_BITS_HOLD'(1);
                end
            end
            ABORT: begin
                if (!bus.cyc_i[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            err_q   <= '0;
            id_q    <= '0;
            last_q  <= N_BITS_ID'(N_MASTERS - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            id_q    <= id_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt_o    = gnt_q;
    assign bus.gnt_id_o = id_q;
    assign bus.busy_o   = |gnt_q;
    assign bus.err_o    = err_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_err_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(err_q));
    a_err_no_gnt: assert property (@(posedge clk) disable iff (rst) (err_q != '0) |-> (gnt_q == '0));
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed vector table, multi-cycle corner
// sequences and randomized CYC traffic compared against an ownership-level model.
module tb_wb_bus_arbiter;
    localparam int N   = 4;
    localparam int MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_bus_arbiter_if #(.N_MASTERS(N)) bus ();

    wb_bus_arbiter #(
        .N_MASTERS      (N),
        .MAX_HOLD_CYCLES(MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Model: who owns the bus, for how many visible cycles, and whether we wait on an aborted master.
    int       m_owner;
    int       m_held;
    bit       m_blocked;
    int       m_last;
    int       m_id;
    logic [3:0] m_err;

    typedef struct {
        logic       rst;
        logic [3:0] cyc;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic [3:0] err;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act[10:0], exp[10:0], $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] c, input logic r);
        if (r) begin
            m_owner   = -1;
            m_held    = 0;
            m_blocked = 0;
            m_last    = N - 1;
            m_id      = 0;
            m_err     = '0;
        end else begin
            m_err = '0;
            if (m_owner >= 0) begin
                if (!c[m_owner]) begin
                    m_owner = -1;
                end else if (m_held == MAX) begin
                    m_err     = 4'(1 << m_owner);
                    m_owner   = -1;
                    m_blocked = 1;
                end else begin
                    m_held++;
                end
            end else if (m_blocked) begin
                if (!c[m_id]) m_blocked = 0;
            end else if (c != 0) begin
                for (int k = 1; k <= N; k++) begin
                    int m;
                    m = (m_last + k) % N;
                    if (m_owner < 0 && c[m]) begin
                        m_owner = m;
                        m_id    = m;
                        m_last  = m;
                        m_held  = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] observed();
        return 32'({bus.gnt_o, bus.gnt_id_o, bus.busy_o, bus.err_o});
    endfunction

    function automatic logic [31:0] predicted();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return 32'({g, 2'(m_id), (m_owner >= 0), m_err});
    endfunction

    task automatic tick(input logic [3:0] c, input logic r);
        bus.cyc_i = c;
        rst       = r;
        @(posedge clk);
        model_edge(c, r);
        #1;
        check("model", observed(), predicted());
    endtask

    task automatic add_vec(input logic r, input logic [3:0] c, input logic [3:0] g,
                           input logic [1:0] id, input logic b, input logic [3:0] e);
        vec_t v;
        v.rst = r; v.cyc = c; v.gnt = g; v.id = id; v.busy = b; v.err = e;
        vq.push_back(v);
    endtask

    initial begin
        int order[5];
        int gnt_cycles;
        int err_pulses;
        int err_at;
        int abort_leaks;
        logic [3:0] cyc_r;

        order = '{0, 1, 2, 3, 0};
        bus.cyc_i = '0;

        // Single requester, no preemption, reset mid-grant.
        add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);
        for (int i = 0; i < 6; i++) add_vec(0, 4'b0001, 4'b0001, 2'd0, 1, 4'b0000);
        add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);
        add_vec(0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0000);
        add_vec(0, 4'b0101, 4'b0100, 2'd2, 1, 4'b0000);
        add_vec(0, 4'b0101, 4'b0100, 2'd2, 1, 4'b0000);
        add_vec(0, 4'b0001, 4'b0000, 2'd2, 0, 4'b0000);
        add_vec(0, 4'b0001, 4'b0001, 2'd0, 1, 4'b0000);
        add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);
        add_vec(0, 4'b1000, 4'b1000, 2'd3, 1, 4'b0000);
        add_vec(1, 4'b1001, 4'b0000, 2'd0, 0, 4'b0000);
        add_vec(0, 4'b1001, 4'b0001, 2'd0, 1, 4'b0000);
        add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);

        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        check("reset_state", observed(), 32'd0);

        foreach (vq[i]) begin
            tick(vq[i].cyc, vq[i].rst);
            check($sformatf("vec%0d", i), observed(),
                  32'({vq[i].gnt, vq[i].id, vq[i].busy, vq[i].err}));
        end

        // Everyone requests; each owner keeps the bus 3 cycles then drops CYC for one.
        tick(4'b0000, 1'b1);
        for (int r = 0; r < 5; r++) begin
            tick(4'b1111, 1'b0);
            check($sformatf("rr_grant%0d", r), 32'(bus.gnt_o), 32'(1 << order[r]));
            tick(4'b1111, 1'b0);
            tick(4'b1111, 1'b0);
            tick(4'b1111 & ~4'(1 << order[r]), 1'b0);
            check($sformatf("rr_gap%0d", r), 32'(bus.busy_o), 32'd0);
        end

        // Watchdog: master 1 holds 20 cycles while master 3 waits.
        gnt_cycles = 0; err_pulses = 0; err_at = 0; abort_leaks = 0;
        for (int t = 1; t <= 20; t++) begin
            tick((t == 1) ? 4'b0010 : 4'b1010, 1'b0);
            if (bus.gnt_o == 4'b0010) gnt_cycles++;
            if (bus.err_o != 4'b0000) begin
                err_pulses++;
                err_at = t;
                check("wd_err_vec", 32'({bus.err_o, bus.gnt_o}), 32'({4'b0010, 4'b0000}));
            end
            if (t > MAX && bus.gnt_o != 4'b0000) abort_leaks++;
        end
        check("wd_gnt_cycles", 32'(gnt_cycles), 32'(MAX));
        check("wd_err_pulses", 32'(err_pulses), 32'd1);
        check("wd_err_time", 32'(err_at), 32'(MAX + 1));
        check("wd_abort_held", 32'(abort_leaks), 32'd0);
        tick(4'b1000, 1'b0);
        check("wd_abort_exit", 32'(bus.gnt_o), 32'd0);
        tick(4'b1010, 1'b0);
        check("wd_next_owner", 32'(bus.gnt_o), 32'b1000);
        tick(4'b0010, 1'b0);
        tick(4'b0000, 1'b0);

        // Release in exactly the MAX-th granted cycle: no abort.
        for (int t = 0; t < MAX; t++) tick(4'b0100, 1'b0);
        check("tie_last_grant", 32'(bus.gnt_o), 32'b0100);
        tick(4'b0000, 1'b0);
        check("tie_release", 32'({bus.gnt_o, bus.err_o}), 32'd0);
        tick(4'b0000, 1'b0);
        check("tie_no_err", 32'(bus.err_o), 32'd0);
        tick(4'b0001, 1'b0);
        check("tie_regrant", 32'(bus.gnt_o), 32'b0001);
        tick(4'b0000, 1'b0);

        // Randomized traffic with long holds and occasional reset.
        cyc_r = '0;
        for (int t = 0; t < 2000; t++) begin
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(0, 9) == 0) cyc_r[m] = ~cyc_r[m];
            end
            tick(cyc_r, ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
